// File: rtl/reg_scoreboard_pkg.sv
// Shared sizes, types and FSM encoding for the register scoreboard.
package reg_scoreboard_pkg;
  localparam int unsigned REG_NUM     = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned SB_CNT_W    = 2;
  localparam int unsigned STALL_CNT_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = sb_cnt_t'(3);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_e;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Bus bundle between the ID/WB pipeline stages and the scoreboard.
// master: pipeline side (drives requests, receives stall/status).
// slave : scoreboard side.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                   id_valid;
  logic                   reg_read_en_1;
  logic                   reg_read_en_2;
  reg_addr_t              reg_addr_1;
  reg_addr_t              reg_addr_2;
  logic                   reg_write_en;
  reg_addr_t              reg_write_addr;
  logic                   wb_write_en;
  reg_addr_t              wb_write_addr;
  logic                   flush;
  logic                   stall;
  logic [REG_NUM-1:0]     pending_mask;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   sb_err;

  modport master (
    output id_valid, reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
           reg_write_en, reg_write_addr, wb_write_en, wb_write_addr, flush,
    input  stall, pending_mask, stall_cycles, sb_err
  );

  modport slave (
    input  id_valid, reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2,
           reg_write_en, reg_write_addr, wb_write_en, wb_write_addr, flush,
    output stall, pending_mask, stall_cycles, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's pending-write counter.
// Ports: clk, rst (sync, active high); inc = issue to this register;
// dec = retire of this register (ignored when the count is already 0);
// clr = flush; cnt = current count; nonzero = cnt != 0.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  input  logic    dec,
  input  logic    clr,
  output sb_cnt_t cnt,
  output logic    nonzero
);
  sb_cnt_t cnt_q, cnt_d;
  logic    dec_ok;

  always_comb begin
    dec_ok = dec && (cnt_q != '0);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec_ok && (cnt_q != SB_CNT_MAX)) begin
      cnt_d = cnt_q + sb_cnt_t'(1);
    end else if (dec_ok && !inc) begin
      cnt_d = cnt_q - sb_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign nonzero = |cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes to r1..r31 and stalls ID on
// RAW hazards (with same-cycle WB bypass), WAW counter saturation, flush and
// the post-flush drain cycle.
// Ports: clk, rst (sync, active high); sb = slave side of reg_scoreboard_if
// (ID/WB requests and flush in; stall, pending_mask, stall_cycles, sb_err out).
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);
  sb_cnt_t                cnt [REG_NUM];
  logic [REG_NUM-1:0]     nz;
  sb_state_e              state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   sb_err_q, sb_err_d;
  logic                   haz1, haz2, waw_full, stall, issue, retire_bad;

  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar i = 1; i < REG_NUM; i++) begin : g_entry
    sb_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .inc     (issue && (sb.reg_write_addr == reg_addr_t'(i))),
      .dec     (sb.wb_write_en && (sb.wb_write_addr == reg_addr_t'(i))),
      .clr     (sb.flush),
      .cnt     (cnt[i]),
      .nonzero (nz[i])
    );
  end

  always_comb begin
    // A read is not hazardous if WB retires the last outstanding write now.
    haz1 = sb.reg_read_en_1 && (sb.reg_addr_1 != '0) && (cnt[sb.reg_addr_1] != '0)
        && !(sb.wb_write_en && (sb.wb_write_addr == sb.reg_addr_1)
             && (cnt[sb.reg_addr_1] == sb_cnt_t'(1)));
    haz2 = sb.reg_read_en_2 && (sb.reg_addr_2 != '0) && (cnt[sb.reg_addr_2] != '0)
        && !(sb.wb_write_en && (sb.wb_write_addr == sb.reg_addr_2)
             && (cnt[sb.reg_addr_2] == sb_cnt_t'(1)));
    waw_full = sb.reg_write_en && (sb.reg_write_addr != '0)
            && (cnt[sb.reg_write_addr] == SB_CNT_MAX);
    stall = sb.id_valid && (haz1 || haz2 || waw_full || (state_q == DRAIN) || sb.flush);
    issue = sb.id_valid && !stall && sb.reg_write_en && (sb.reg_write_addr != '0);
    // Retires in a flush cycle are discarded, so they cannot flag an error.
    retire_bad = sb.wb_write_en && (sb.wb_write_addr != '0)
              && (cnt[sb.wb_write_addr] == '0) && !sb.flush;

    state_d        = sb.flush ? DRAIN : RUN;
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    sb_err_d       = sb_err_q || retire_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      sb_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign sb.stall        = stall;
  // Pure decode of the counter flops: no combinational path from inputs.
  assign sb.pending_mask = nz;
  assign sb.stall_cycles = stall_cycles_q;
  assign sb.sb_err       = sb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if ifc ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending write count per register, drain flag, counters.
  int m_cnt [32];
  bit m_drain = 1'b0;
  int m_sc    = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_haz(input bit en, input int a);
    return en && (a != 0) && (m_cnt[a] > 0)
        && !(ifc.wb_write_en && (int'(ifc.wb_write_addr) == a) && (m_cnt[a] == 1));
  endfunction

  function automatic bit m_stall();
    int wa;
    bit full;
    wa   = int'(ifc.reg_write_addr);
    full = ifc.reg_write_en && (wa != 0) && (m_cnt[wa] == 3);
    return ifc.id_valid && (m_haz(ifc.reg_read_en_1, int'(ifc.reg_addr_1)) ||
                            m_haz(ifc.reg_read_en_2, int'(ifc.reg_addr_2)) ||
                            full || m_drain || ifc.flush);
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive(input bit v, input bit r1, input int a1, input bit r2, input int a2,
                       input bit we, input int wa, input bit wb, input int wba,
                       input bit fl, input bit rs);
    ifc.id_valid       = v;
    ifc.reg_read_en_1  = r1;
    ifc.reg_addr_1     = 5'(a1);
    ifc.reg_read_en_2  = r2;
    ifc.reg_addr_2     = 5'(a2);
    ifc.reg_write_en   = we;
    ifc.reg_write_addr = 5'(wa);
    ifc.wb_write_en    = wb;
    ifc.wb_write_addr  = 5'(wba);
    ifc.flush          = fl;
    rst                = rs;
  endtask

  // One clock: check stall before the edge, advance the model on the edge,
  // check the registered outputs just after it.
  task automatic cyc();
    bit s;
    int wa, wba;
    bit ok;
    #2;
    s = m_stall();
    chk("stall", 32'(ifc.stall), 32'(s));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_drain = 1'b0;
      m_sc    = 0;
      m_err   = 1'b0;
    end else begin
      if (s && (m_sc < 65535)) m_sc++;
      if (ifc.flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_drain = 1'b1;
      end else begin
        m_drain = 1'b0;
        wa  = int'(ifc.reg_write_addr);
        wba = int'(ifc.wb_write_addr);
        ok  = ifc.wb_write_en && (wba != 0) && (m_cnt[wba] > 0);
        if (ifc.wb_write_en && (wba != 0) && (m_cnt[wba] == 0)) m_err = 1'b1;
        if (ifc.id_valid && !s && ifc.reg_write_en && (wa != 0)) m_cnt[wa]++;
        if (ok) m_cnt[wba]--;
      end
    end
    #1;
    chk("pending_mask", ifc.pending_mask, m_mask());
    chk("stall_cycles", 32'(ifc.stall_cycles), 32'(m_sc));
    chk("sb_err", 32'(ifc.sb_err), 32'(m_err));
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    int pend [$];
    bit wb;
    int wba;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("rst_mask", ifc.pending_mask, 32'h0);
    chk("rst_sc", 32'(ifc.stall_cycles), 32'h0);
    chk("rst_err", 32'(ifc.sb_err), 32'h0);

    // Load-use on r5 with WB bypass
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); cyc();
    chk("lu_pend", 32'(ifc.pending_mask[5]), 32'h1);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_stall", 32'(ifc.stall), 32'h1);
    cyc(); cyc();
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
    #1 chk("lu_bypass", 32'(ifc.stall), 32'h0);
    cyc();
    chk("lu_clear", 32'(ifc.pending_mask[5]), 32'h0);

    // Register 0 is never tracked
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("r0_wr_stall", 32'(ifc.stall), 32'h0);
    cyc();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_rd_stall", 32'(ifc.stall), 32'h0);
    cyc();
    chk("r0_mask", ifc.pending_mask, 32'h0);

    // WAW saturation on r7
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    base = m_sc;
    #1 chk("waw_full_stall", 32'(ifc.stall), 32'h1);
    cyc(); cyc(); cyc();
    chk("waw_sc", 32'(ifc.stall_cycles), 32'(base + 3));
    drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    #1 chk("waw_release", 32'(ifc.stall), 32'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0); cyc(); cyc(); cyc();
    chk("waw_drained", ifc.pending_mask, 32'h0);

    // Simultaneous issue and retire on r9
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0); cyc();
    chk("sim_pend", 32'(ifc.pending_mask[9]), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); cyc();
    chk("sim_one", 32'(ifc.pending_mask[9]), 32'h0);

    // Flush with r3, r4, r10 pending
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0); cyc();
    chk("fl_pend", ifc.pending_mask, 32'h0000_0418);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("fl_stall", 32'(ifc.stall), 32'h1);
    cyc();
    chk("fl_mask", ifc.pending_mask, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_drain_stall", 32'(ifc.stall), 32'h1);
    cyc();
    #1 chk("fl_run", 32'(ifc.stall), 32'h0);
    cyc();

    // Orphan retire sets sticky error; reset clears everything
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0); cyc();
    chk("err_set", 32'(ifc.sb_err), 32'h1);
    idle(); cyc(); cyc();
    chk("err_sticky", 32'(ifc.sb_err), 32'h1);
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0); cyc();
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    chk("rst_err2", 32'(ifc.sb_err), 32'h0);
    chk("rst_sc2", 32'(ifc.stall_cycles), 32'h0);
    chk("rst_mask2", ifc.pending_mask, 32'h0);
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_release", 32'(ifc.stall), 32'h0);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      pend.delete();
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) pend.push_back(i);
      wb  = 1'b0;
      wba = 0;
      if ($urandom_range(0, 19) == 0) begin
        wb  = 1'b1;
        wba = int'($urandom_range(0, 7));
      end else if ((pend.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        wb  = 1'b1;
        wba = pend[$urandom_range(0, pend.size() - 1)];
      end
      drive($urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            wb, wba,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 199) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 id_valid  input  1  the ID stage holds a valid instruction this cycle.
REQ-005 reg_read_en_1 / reg_read_en_2  input  1 each  source operand 1 / source operand 2 is read.
REQ-006 reg_addr_1 / reg_addr_2  input  5 each  source register addresses.
REQ-007 reg_write_en  input  1  the ID instruction writes a register.
REQ-008 reg_write_addr  input  5  destination register address.
REQ-009 wb_write_en  input  1  the WB stage retires a register write this cycle.
REQ-010 wb_write_addr  input  5  retiring destination address.
REQ-011 flush  input  1  all in-flight instructions are killed; none of them will assert wb_write_en afterwards.
REQ-012 stall  output  1  combinational; holds ID and everything upstream of it.
REQ-013 pending_mask  output  32  registered; bit n = 1 when cnt[n] != 0.
REQ-014 stall_cycles  output  16  registered, saturating count of stalled cycles.
REQ-015 sb_err  output  1  registered, sticky; set when a retire arrives with no matching pending write.

Function
REQ-016 The block SHALL keep a 2-bit pending counter cnt[n] for each of registers 1..31, with maximum value 3; register 0 is never tracked and is never hazardous.
REQ-017 The FSM SHALL have two states: RUN and DRAIN.
REQ-018 RUN SHALL go to DRAIN when flush=1; DRAIN SHALL go to RUN when flush=0; DRAIN SHALL stay in DRAIN while flush=1.
REQ-019 A read hazard x SHALL exist when all of these hold: read_en_x=1, addr_x != 0, cnt[addr_x] != 0, and NOT (wb_write_en=1 and wb_write_addr=addr_x and cnt[addr_x]=1). The last term is the same-cycle WB bypass.
REQ-020 A WAW-full condition SHALL exist when reg_write_en=1, reg_write_addr != 0, and cnt[reg_write_addr]=3.
REQ-021 stall SHALL be id_valid AND (hazard1 OR hazard2 OR WAW-full OR state=DRAIN OR flush).
REQ-022 issue SHALL be id_valid AND NOT stall AND reg_write_en AND reg_write_addr != 0.
REQ-023 For each register, on the next edge:
- issue only: increment.
- valid retire only: decrement.
- both in the same cycle: unchanged.
- neither: unchanged.
REQ-024 A retire with cnt=0 or wb_write_addr=0 SHALL leave the counters unchanged; the cnt=0 case with a nonzero address SHALL set sb_err.
REQ-025 flush=1 SHALL clear every counter on the next edge. Issue and retire in that same cycle SHALL be ignored, and issue is already blocked by REQ-021.
REQ-026 pending_mask SHALL reflect the counter values after the update, with one cycle of latency from issue or retire.
REQ-027 stall_cycles SHALL increment on every edge where stall=1 and SHALL saturate at 0xFFFF.
REQ-028 stall SHALL depend only on the current inputs and current state, with no registered delay.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL happen on that edge, overriding flush, issue and retire:
- all cnt=0, FSM=RUN;
- pending_mask=0, stall_cycles=0, sb_err=0.
REQ-030 A reset asserted mid-stall SHALL release stall on the next cycle unless flush is high; stall remains combinational per REQ-021.

Structure
REQ-031 A shared package SHALL hold REG_NUM=32, REG_ADDR_W=5, SB_CNT_W=2, SB_CNT_MAX=3, STALL_CNT_W=16, and the FSM state encoding {RUN, DRAIN}.
REQ-032 The per-register counter (inc, dec, clr, cnt, nonzero) SHALL be a sub-module named sb_entry, instantiated 31 times; the FSM, hazard logic and performance counter stay in reg_scoreboard.

Verification
REQ-033 Load-use: issue a write to r5 with cnt[5]=0, then next cycle read r5 -> stall=1 until the cycle wb_write_addr=5, in which stall=0 (bypass); pending_mask[5] then returns to 0.
REQ-034 Register 0: write r0, then read r0 -> stall=0 throughout, pending_mask=0.
REQ-035 WAW saturation: three back-to-back issues to r7 give cnt=3; a fourth write to r7 -> stall=1 until a retire of r7, with stall_cycles incrementing by 1 per stalled cycle.
REQ-036 Simultaneous issue and retire: with cnt[9]=1, issue r9 and retire r9 in the same cycle -> cnt[9] stays 1 and pending_mask[9]=1.
REQ-037 Flush: with r3, r4 and r10 pending, pulse flush for 1 cycle -> stall=1 in the flush cycle and in the DRAIN cycle, pending_mask=0 after the flush edge, FSM back to RUN after 2 edges.
REQ-038 Error and reset: retire r12 with cnt=0 -> sb_err=1 and stays 1; assert rst -> sb_err=0, stall_cycles=0, pending_mask=0.
